// File: rtl/fact_bus_pkg.sv
// Shared bus widths, factorial register map and host sequencer states.
// No logic; used by the host controller, its sub-blocks and the bench.
// The window helper is the single definition of "address hits the core".
package fact_bus_pkg;

  localparam int BUS_DW = 64;
  localparam int BUS_AW = 16;

  // Register offsets inside the factorial core window
  localparam logic [BUS_AW-1:0] OFF_OPSTART = 16'h0000;
  localparam logic [BUS_AW-1:0] OFF_OPCLEAR = 16'h0008;
  localparam logic [BUS_AW-1:0] OFF_OPDONE  = 16'h0010;
  localparam logic [BUS_AW-1:0] OFF_INTREN  = 16'h0018;
  localparam logic [BUS_AW-1:0] OFF_OPERAND = 16'h0020;
  localparam logic [BUS_AW-1:0] OFF_RES_H   = 16'h0028;
  localparam logic [BUS_AW-1:0] OFF_RES_L   = 16'h0030;

  // Size of the register window that destination writes must avoid
  localparam logic [BUS_AW-1:0] WIN_SIZE    = 16'h1000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_OPND,
    ST_WR_IEN,
    ST_WR_START,
    ST_WAIT_INT,
    ST_POLL_A,
    ST_POLL_D,
    ST_RD_H_A,
    ST_RD_H_D,
    ST_WR_H,
    ST_RD_L_A,
    ST_RD_L_D,
    ST_WR_L,
    ST_WR_CLR
  } host_state_e;

  // True when addr lies in [base, base+WIN_SIZE-1]; the subtraction wraps
  function automatic logic in_window(input logic [BUS_AW-1:0] addr,
                                     input logic [BUS_AW-1:0] base);
    logic [BUS_AW-1:0] delta;
    delta = addr - base;
    return (delta < WIN_SIZE);
  endfunction

endpackage

// File: rtl/fact_host_ctrl_if.sv
// Command channel and shared memory-bus channel of the factorial host.
// Command is valid/ready; the bus is request/grant with 1-cycle read data.
// master modports belong to the side that initiates each channel.
interface fact_cmd_if;
  import fact_bus_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [BUS_DW-1:0] cmd_operand;
  logic [BUS_AW-1:0] cmd_dst;
  logic              cmd_use_intr;

  modport master (output cmd_valid, cmd_operand, cmd_dst, cmd_use_intr,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_operand, cmd_dst, cmd_use_intr,
                  output cmd_ready);
endinterface

interface fact_mbus_if;
  import fact_bus_pkg::*;

  logic              m_req;
  logic              m_wr;
  logic [BUS_AW-1:0] m_addr;
  logic [BUS_DW-1:0] m_dout;
  logic              m_grant;
  logic [BUS_DW-1:0] m_din;

  modport master (output m_req, m_wr, m_addr, m_dout,
                  input  m_grant, m_din);
  modport slave  (input  m_req, m_wr, m_addr, m_dout,
                  output m_grant, m_din);
endinterface

// File: rtl/fact_wdt.sv
// Completion watchdog: loadable down-counter with an expire flag.
// Latency: expire_o is combinational on the count, one cycle before timeout.
// No backpressure; counts only while en_i is high.
module fact_wdt #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counts cycles left before the abort cycle; the cycle of the start
  // transfer is cycle 0, so the abort lands TIMEOUT_CYCLES cycles later.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(TIMEOUT_CYCLES - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CW'(1));

endmodule

// File: rtl/fact_host_ctrl.sv
// Bus-master sequencer: programs the factorial core, waits, copies results out.
// Latency: 12 cycles accept-to-done with grant held and interrupt already high.
// Backpressure: every bus state stalls on m_grant=0; cmd_ready only in IDLE.
module fact_host_ctrl
  import fact_bus_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 2048,
  parameter logic [15:0] BASE_ADDR      = 16'h7000
) (
  input  logic              clk,
  input  logic              reset_n,
  fact_cmd_if.slave         cmd,
  fact_mbus_if.master       mbus,
  input  logic              interrupt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BUS_DW-1:0] result_h,
  output logic [BUS_DW-1:0] result_l
);

  host_state_e       state_q, state_d;
  logic [BUS_DW-1:0] operand_q;
  logic [BUS_AW-1:0] dst_q;
  logic              use_intr_q;
  logic [BUS_DW-1:0] res_h_q, res_l_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              tmo_q;
  logic              rdy_q;

  logic              cmd_ready_w, take, dst_bad;
  logic              cap_h, cap_l, set_tmo, wdt_load, wdt_en, wdt_expire;
  logic              bus_req, bus_wr;
  logic [BUS_AW-1:0] bus_addr;
  logic [BUS_DW-1:0] bus_dout;

  // rdy_q keeps cmd_ready low while reset is asserted even though the FSM
  // already sits in IDLE.
  assign cmd_ready_w   = rdy_q & (state_q == ST_IDLE);
  assign cmd.cmd_ready = cmd_ready_w;
  assign take          = cmd.cmd_valid & cmd_ready_w;
  // Either result word landing in the core window would corrupt the core
  assign dst_bad       = in_window(cmd.cmd_dst, BASE_ADDR) |
                         in_window(cmd.cmd_dst + 16'd8, BASE_ADDR);

  fact_wdt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdt (
    .clk      (clk),
    .rst_n    (reset_n),
    .load_i   (wdt_load),
    .en_i     (wdt_en),
    .expire_o (wdt_expire)
  );

  // Next state, bus drive and one-cycle strobes; bus fields are pure
  // functions of state so they stay put while a transfer is stalled.
  always_comb begin
    state_d  = state_q;
    bus_req  = 1'b0;
    bus_wr   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cap_h    = 1'b0;
    cap_l    = 1'b0;
    set_tmo  = 1'b0;
    wdt_load = 1'b0;
    wdt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          if (dst_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = ST_WR_OPND;
          end
        end
      end
      ST_WR_OPND: begin
        bus_req = 1'b1; bus_wr = 1'b1;
        bus_addr = BASE_ADDR + OFF_OPERAND; bus_dout = operand_q;
        if (mbus.m_grant) state_d = ST_WR_IEN;
      end
      ST_WR_IEN: begin
        bus_req = 1'b1; bus_wr = 1'b1;
        bus_addr = BASE_ADDR + OFF_INTREN; bus_dout = {63'b0, use_intr_q};
        if (mbus.m_grant) state_d = ST_WR_START;
      end
      ST_WR_START: begin
        bus_req = 1'b1; bus_wr = 1'b1;
        bus_addr = BASE_ADDR + OFF_OPSTART; bus_dout = 64'd1;
        if (mbus.m_grant) begin
          wdt_load = 1'b1;
          state_d  = use_intr_q ? ST_WAIT_INT : ST_POLL_A;
        end
      end
      ST_WAIT_INT: begin
        // Bus released while the core computes
        wdt_en = 1'b1;
        if (wdt_expire) begin
          set_tmo = 1'b1;
          state_d = ST_WR_CLR;
        end else if (interrupt) begin
          state_d = ST_RD_H_A;
        end
      end
      ST_POLL_A, ST_POLL_D: begin
        bus_req = 1'b1;
        bus_addr = BASE_ADDR + OFF_OPDONE;
        wdt_en = 1'b1;
        if (wdt_expire) begin
          set_tmo = 1'b1;
          state_d = ST_WR_CLR;
        end else if (mbus.m_grant) begin
          if (state_q == ST_POLL_A) state_d = ST_POLL_D;
          else state_d = mbus.m_din[0] ? ST_RD_H_A : ST_POLL_A;
        end
      end
      ST_RD_H_A, ST_RD_H_D: begin
        bus_req = 1'b1;
        bus_addr = BASE_ADDR + OFF_RES_H;
        if (mbus.m_grant) begin
          if (state_q == ST_RD_H_A) state_d = ST_RD_H_D;
          else begin
            cap_h   = 1'b1;
            state_d = ST_WR_H;
          end
        end
      end
      ST_WR_H: begin
        bus_req = 1'b1; bus_wr = 1'b1;
        bus_addr = dst_q; bus_dout = res_h_q;
        if (mbus.m_grant) state_d = ST_RD_L_A;
      end
      ST_RD_L_A, ST_RD_L_D: begin
        bus_req = 1'b1;
        bus_addr = BASE_ADDR + OFF_RES_L;
        if (mbus.m_grant) begin
          if (state_q == ST_RD_L_A) state_d = ST_RD_L_D;
          else begin
            cap_l   = 1'b1;
            state_d = ST_WR_L;
          end
        end
      end
      ST_WR_L: begin
        bus_req = 1'b1; bus_wr = 1'b1;
        bus_addr = dst_q + 16'd8; bus_dout = res_l_q;
        if (mbus.m_grant) state_d = ST_WR_CLR;
      end
      ST_WR_CLR: begin
        bus_req = 1'b1; bus_wr = 1'b1;
        bus_addr = BASE_ADDR + OFF_OPCLEAR; bus_dout = 64'd1;
        if (mbus.m_grant) begin
          done_d  = 1'b1;
          err_d   = tmo_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched command, captured results and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      operand_q  <= '0;
      dst_q      <= '0;
      use_intr_q <= 1'b0;
      res_h_q    <= '0;
      res_l_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
      if (take) begin
        operand_q  <= cmd.cmd_operand;
        dst_q      <= cmd.cmd_dst;
        use_intr_q <= cmd.cmd_use_intr;
        tmo_q      <= 1'b0;
      end
      if (set_tmo) tmo_q <= 1'b1;
      if (cap_h) res_h_q <= mbus.m_din;
      if (cap_l) res_l_q <= mbus.m_din;
    end
  end

  assign mbus.m_req  = bus_req;
  assign mbus.m_wr   = bus_wr;
  assign mbus.m_addr = bus_addr;
  assign mbus.m_dout = bus_dout;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign result_h    = res_h_q;
  assign result_l    = res_l_q;

endmodule

// File: tb/tb_fact_host_ctrl.sv
// Bench for fact_host_ctrl: bus memory plus a behavioural factorial core.
// Directed commands with hand-computed expectations; one check task.
// Grant can be held high or toggled every cycle to exercise stalls.
module tb_fact_host_ctrl;
  import fact_bus_pkg::*;

  localparam logic [15:0] BASE = 16'h7000;
  localparam int          TMO  = 64;
  localparam logic [63:0] PAT  = 64'hA5A5_5A5A_DEAD_BEEF;

  logic        clk;
  logic        reset_n;
  logic        interrupt;
  logic        busy, done, err;
  logic [63:0] result_h, result_l;

  fact_cmd_if  cmd ();
  fact_mbus_if mbus ();

  fact_host_ctrl #(.TIMEOUT_CYCLES(TMO), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd       (cmd),
    .mbus      (mbus),
    .interrupt (interrupt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result_h  (result_h),
    .result_l  (result_l)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // ---------------- core and memory model ----------------
  logic [63:0]  dmem [0:8191] = '{default: PAT};
  logic [63:0]  rdata_q   = '0;
  logic [63:0]  operand_m = '0;
  logic         ien_m     = 1'b0;
  logic         opdone_m  = 1'b0;
  logic [127:0] res_m     = '0;
  int           dcnt      = 0;
  int           nxfer     = 0;
  int           nclr      = 0;
  int           start_cyc = 0;
  int           clr_cyc   = 0;
  int           poll_zero = 0;
  int           poll_one  = 0;
  logic [15:0]  wlog_a [$];
  logic [63:0]  wlog_d [$];

  int   core_delay = 3;
  logic intr_allow = 1'b1;
  logic intr_force = 1'b0;
  logic gmode      = 1'b0;

  function automatic logic [127:0] fact(input logic [63:0] n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 2; i <= int'(n) && i <= 34; i++) r = r * 128'(i);
    return r;
  endfunction

  assign interrupt  = (opdone_m & ien_m & intr_allow) | intr_force;
  assign mbus.m_din = rdata_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    mbus.m_grant = 1'b1;
    forever begin
      @(negedge clk);
      mbus.m_grant = gmode ? ~mbus.m_grant : 1'b1;
    end
  end

  always @(posedge clk) begin
    if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) opdone_m <= 1'b1;
    end
    if (mbus.m_req && mbus.m_grant) begin
      nxfer <= nxfer + 1;
      if (mbus.m_wr) begin
        wlog_a.push_back(mbus.m_addr);
        wlog_d.push_back(mbus.m_dout);
        case (mbus.m_addr)
          BASE + OFF_OPERAND: operand_m <= mbus.m_dout;
          BASE + OFF_INTREN:  ien_m <= mbus.m_dout[0];
          BASE + OFF_OPSTART: begin
            opdone_m  <= 1'b0;
            dcnt      <= core_delay;
            res_m     <= fact(operand_m);
            start_cyc <= cyc;
          end
          BASE + OFF_OPCLEAR: begin
            opdone_m <= 1'b0;
            nclr     <= nclr + 1;
            clr_cyc  <= cyc;
          end
          default: dmem[mbus.m_addr[15:3]] <= mbus.m_dout;
        endcase
      end else begin
        case (mbus.m_addr)
          BASE + OFF_OPDONE: begin
            rdata_q <= {63'b0, opdone_m};
            if (opdone_m) poll_one <= poll_one + 1;
            else poll_zero <= poll_zero + 1;
          end
          BASE + OFF_RES_H: rdata_q <= res_m[127:64];
          BASE + OFF_RES_L: rdata_q <= res_m[63:0];
          default:          rdata_q <= dmem[mbus.m_addr[15:3]];
        endcase
      end
    end
  end

  // ---------------- checking and stimulus ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_only(input logic [63:0] op, input logic [15:0] dst,
                           input logic intr, output int acc);
    @(negedge clk);
    cmd.cmd_valid    = 1'b1;
    cmd.cmd_operand  = op;
    cmd.cmd_dst      = dst;
    cmd.cmd_use_intr = intr;
    for (int i = 0; i < 100 && !cmd.cmd_ready; i++) @(negedge clk);
    chk("cmd_accept", {63'b0, cmd.cmd_ready}, 64'd1);
    acc = cyc;
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [63:0] op, input logic [15:0] dst, input logic intr,
                         output int acc, output int dc, output logic e);
    send_only(op, dst, intr, acc);
    dc = -1;
    e  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        dc = cyc;
        e  = err;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", {63'b0, done}, 64'd1);
    @(negedge clk);
    chk("done_pulse", {63'b0, done}, 64'd0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within 20000 cycles");
    $fatal(1);
  end

  initial begin
    int          acc, dc, x0, c0, pz0, lo;
    logic        e;
    logic [15:0] exp_a [6];
    logic [63:0] exp_d [6];

    reset_n          = 1'b0;
    cmd.cmd_valid    = 1'b0;
    cmd.cmd_operand  = '0;
    cmd.cmd_dst      = '0;
    cmd.cmd_use_intr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {63'b0, cmd.cmd_ready}, 64'd0);
    chk("rst_m_req",     {63'b0, mbus.m_req},    64'd0);
    chk("rst_busy",      {63'b0, busy},          64'd0);
    chk("rst_m_addr",    {48'b0, mbus.m_addr},   64'd0);
    chk("rst_result_l",  result_l,               64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {63'b0, cmd.cmd_ready}, 64'd1);

    // 7! by interrupt
    core_delay = 3;
    run_cmd(64'd7, 16'h0080, 1'b1, acc, dc, e);
    chk("t1_err",   {63'b0, e}, 64'd0);
    chk("t1_res_h", result_h, 64'd0);
    chk("t1_res_l", result_l, 64'd5040);
    chk("t1_mem_h", dmem[16'h0080 >> 3], 64'd0);
    chk("t1_mem_l", dmem[16'h0088 >> 3], 64'd5040);

    // 5! by polling; core slow enough that opdone reads 0 first
    pz0 = poll_zero;
    core_delay = 6;
    run_cmd(64'd5, 16'h0030, 1'b0, acc, dc, e);
    chk("t2_err",       {63'b0, e}, 64'd0);
    chk("t2_poll_zero", {63'b0, (poll_zero > pz0)}, 64'd1);
    chk("t2_poll_one",  {63'b0, (poll_one > 0)}, 64'd1);
    chk("t2_res_l",     result_l, 64'd120);
    chk("t2_mem_l",     dmem[16'h0038 >> 3], 64'd120);

    // 10! with grant toggling every cycle: write order must be intact
    exp_a = '{16'h7020, 16'h7018, 16'h7000, 16'h0100, 16'h0108, 16'h7008};
    exp_d = '{64'd10, 64'd1, 64'd1, 64'd0, 64'd3628800, 64'd1};
    lo = wlog_a.size();
    gmode = 1'b1;
    core_delay = 4;
    run_cmd(64'd10, 16'h0100, 1'b1, acc, dc, e);
    gmode = 1'b0;
    chk("t3_nwrites", 64'(wlog_a.size() - lo), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (lo + i < wlog_a.size()) begin
        chk($sformatf("t3_wr%0d_addr", i), {48'b0, wlog_a[lo+i]}, {48'b0, exp_a[i]});
        chk($sformatf("t3_wr%0d_data", i), wlog_d[lo+i], exp_d[i]);
      end
    end
    chk("t3_res_l", result_l, 64'd3628800);

    // Minimum latency with the interrupt already asserted
    intr_force = 1'b1;
    run_cmd(64'd3, 16'h0200, 1'b1, acc, dc, e);
    intr_force = 1'b0;
    chk("t4_latency", 64'(dc - acc), 64'd12);
    chk("t4_res_l",   result_l, 64'd6);

    // Interrupt never arrives: abort via opclear, results untouched
    intr_allow = 1'b0;
    c0 = nclr;
    run_cmd(64'd4, 16'h0300, 1'b1, acc, dc, e);
    intr_allow = 1'b1;
    chk("t5_err",       {63'b0, e}, 64'd1);
    chk("t5_clr_delta", 64'(clr_cyc - start_cyc), 64'd64);
    chk("t5_nclr",      64'(nclr - c0), 64'd1);
    chk("t5_res_l",     result_l, 64'd6);
    chk("t5_mem",       dmem[16'h0300 >> 3], PAT);

    // Destinations touching the core window: no bus traffic at all
    x0 = nxfer;
    run_cmd(64'd0, 16'h7008, 1'b1, acc, dc, e);
    chk("t6_err",   {63'b0, e}, 64'd1);
    chk("t6_lat",   64'(dc - acc), 64'd1);
    chk("t6_xfers", 64'(nxfer - x0), 64'd0);
    x0 = nxfer;
    run_cmd(64'd0, 16'h6FFC, 1'b1, acc, dc, e);
    chk("t6b_err",   {63'b0, e}, 64'd1);
    chk("t6b_xfers", 64'(nxfer - x0), 64'd0);
    run_cmd(64'd2, 16'h6FF0, 1'b1, acc, dc, e);
    chk("t6c_err",   {63'b0, e}, 64'd0);
    chk("t6c_mem_l", dmem[16'h6FF8 >> 3], 64'd2);

    // Reset while waiting for the interrupt, then a clean command
    intr_allow = 1'b0;
    send_only(64'd7, 16'h0400, 1'b1, acc);
    repeat (7) @(negedge clk);
    chk("t7_busy_wait", {63'b0, busy},      64'd1);
    chk("t7_req_wait",  {63'b0, mbus.m_req}, 64'd0);
    c0 = nclr;
    reset_n = 1'b0;
    #1;
    chk("t7_rst_busy",  {63'b0, busy},          64'd0);
    chk("t7_rst_req",   {63'b0, mbus.m_req},    64'd0);
    chk("t7_rst_wr",    {63'b0, mbus.m_wr},     64'd0);
    chk("t7_rst_dout",  mbus.m_dout,            64'd0);
    chk("t7_rst_ready", {63'b0, cmd.cmd_ready}, 64'd0);
    chk("t7_rst_res_l", result_l,               64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    intr_allow = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_no_clr", 64'(nclr - c0), 64'd0);
    core_delay = 3;
    run_cmd(64'd7, 16'h0400, 1'b1, acc, dc, e);
    chk("t7_err",   {63'b0, e}, 64'd0);
    chk("t7_res_l", result_l, 64'd5040);
    chk("t7_mem_l", dmem[16'h0408 >> 3], 64'd5040);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fact_host_ctrl.md
# fact_host_ctrl

Bus-master sequencer sitting directly upstream of the factorial core on the shared 64-bit memory bus. Accepts one command (operand, destination address, mode), programs the core's register window, waits for completion by interrupt or polling, copies result_h/result_l into memory at the destination, and clears the core. Replaces hand-driven register traffic so software-less tests and the future CPU path share one master.

## Interface
- TIMEOUT_CYCLES, 2048: max cycles waited for completion before abort.
- BASE_ADDR, 16'h7000: factorial register window base.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in IDLE only; a command is taken when cmd_valid & cmd_ready.
- cmd_operand  in  64  operand n.
- cmd_dst  in  16  memory address for result_h; result_l goes to cmd_dst+8.
- cmd_use_intr  in  1  1 = wait on interrupt, 0 = poll opdone.
- m_req  out  1  bus request.
- m_wr  out  1  1 = write, 0 = read.
- m_addr  out  16  bus address.
- m_dout  out  64  write data.
- m_grant  in  1  arbiter grant; a transfer occurs only in a cycle with m_req & m_grant.
- m_din  in  64  read data, valid one cycle after the read address cycle.
- interrupt  in  1  level interrupt from core.
- busy  out  1  not IDLE.
- done  out  1  one-cycle pulse at end of command.
- err  out  1  one-cycle pulse with done on timeout or illegal cmd_dst.
- result_h, result_l  out  64 each  last results read, held until next command.

## Operation
- Register offsets from BASE_ADDR: opstart +0x00, opclear +0x08, opdone +0x10, intrEn +0x18, operand +0x20, result_h +0x28, result_l +0x30.
- States: IDLE → WR_OPND → WR_IEN → WR_START → (WAIT_INT | POLL_A → POLL_D) → RD_H_A → RD_H_D → WR_H → RD_L_A → RD_L_D → WR_L → WR_CLR → IDLE.
- WR_OPND writes cmd_operand; WR_IEN writes {63'b0, cmd_use_intr}; WR_START writes 1.
- WAIT_INT: m_req=0 (bus released); on interrupt=1 go to RD_H_A with m_req reasserted.
- POLL_A/POLL_D: read opdone; bit0=1 → RD_H_A, else back to POLL_A.
- RD_x_A presents read address; RD_x_D holds m_req, m_wr=0, and captures m_din into result_x.
- WR_H writes result_h to cmd_dst; WR_L writes result_l to cmd_dst+8 (mod 2^16, wraps).
- WR_CLR writes 1 to opclear, then done pulses.
- Timeout: counter starts at WR_START transfer, runs in WAIT_INT/POLL states; reaching TIMEOUT_CYCLES → WR_CLR, skip result copies, result_h/l unchanged, done+err.
- cmd_dst inside [BASE_ADDR, BASE_ADDR+0x0FFF] or cmd_dst+8 wrapping into it: command accepted, no bus traffic, done+err next cycle.

## Timing
- Reset: m_req, m_wr, m_addr, m_dout, cmd_ready(=0 during reset, 1 after), busy, done, err, result_h, result_l all 0; state IDLE; counter 0.
- Every bus state waits with outputs stable while m_grant=0; advances one state per granted cycle.
- Grant loss mid-sequence: stall, no repeat, no skip; a stalled RD_x_D captures only on a granted cycle.
- Minimum latency (intr mode, grant always high, interrupt already high): command accept to done = 12 cycles.
- Reset mid-operation: abort immediately, no opclear issued.
- cmd_valid ignored while busy.

## Structure
- Package fact_bus_pkg: register offset constants, state enum, bus width constants; shared with core and tb.
- Sub-module fact_wdt: loadable down-counter with expire flag, parameterised TIMEOUT_CYCLES.

## Test plan
- operand 7, dst 0x0080, intr mode -> result_l=5040, result_h=0; mem[0x0080]=0, mem[0x0088]=5040; done pulse, err=0.
- operand 5, dst 0x0030, poll mode -> ≥1 opdone read returning 0 before 1; mem[0x0038]=120.
- Grant toggled 1/0 every cycle during operand 10 -> same transfer order, no duplicates, result_l=3628800.
- Core interrupt never raised, TIMEOUT_CYCLES=64 -> opclear write at cycle 64 after start, done+err, result_h/l unchanged.
- cmd_dst 0x7008 -> zero bus transfers, done+err one cycle after accept.
- reset_n low during WAIT_INT -> all outputs 0 same cycle; new command after release completes correctly.
